updown_mod_counter_7seg: RTL

//   Parametrised up/down modulo-N counter with clock prescaler, enable, synchronous load,

---
 rtl/updown_mod_counter_7seg.sv | 114 +++++++++++
 1 files changed

// File: rtl/updown_mod_counter_7seg.sv
// Up/down modulo-N counter with clock prescaler, enable, synchronous load,
// one-cycle wrap pulse and a registered multi-digit hex 7-segment decode.
module updown_mod_counter_7seg #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int DIV     = 5,
  parameter int DIGITS  = 1
) (
  input  logic                key0,
  input  logic                reset,
  input  logic                sw0,
  input  logic                en,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  output logic [WIDTH-1:0]    count,
  output logic                wrap,
  output logic [7*DIGITS-1:0] hex
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MAXV   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MODC   = (WIDTH + 1)'(MODULUS);
  localparam logic [DW-1:0]    DIVMAX = DW'(DIV - 1);
  localparam logic [6:0]       GLYPH0 = 7'b0000001;

  logic [DW-1:0]       div_q, div_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                wrap_q, wrap_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic [4*DIGITS-1:0] nibbles;
  logic                step_ok;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Load pre-empts the prescaler, so a step can only happen on a non-load cycle.
  assign step_ok = en && !load && (div_q == DIVMAX);

  always_comb begin
    div_d   = div_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      div_d   = '0;
      count_d = ({1'b0, load_val} >= MODC) ? MAXV : load_val;
    end else if (step_ok) begin
      div_d = '0;
      if (sw0) begin
        if (count_q == MAXV) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAXV;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end else if (en) begin
      div_d = div_q + 1'b1;
    end
  end

  // Digits beyond the count width see zero nibbles and display "0".
  always_comb begin
    nibbles = '0;
    nibbles[WIDTH-1:0] = count_q;
    hex_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      hex_d[7*i +: 7] = seg7(nibbles[4*i +: 4]);
    end
  end

  always_ff @(posedge key0) begin
    if (reset) begin
      div_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      hex_q   <= {DIGITS{GLYPH0}};
    end else begin
      div_q   <= div_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      hex_q   <= hex_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign hex   = hex_q;
endmodule
